// File: rtl/math_pkg.sv
`default_nettype none
// ============================================================================
// math_pkg : shared constants, FSM state type and factorial helper
// Rev 1.0
// ============================================================================
package math_pkg;

  localparam int FACT_W    = 32;
  localparam int FACT_NMAX = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Loop bounded by FACT_NMAX so the function also elaborates in synthesis
  function automatic logic [FACT_W-1:0] fact_ref(input int unsigned n);
    logic [FACT_W-1:0] f;
    f = FACT_W'(1);
    for (int i = 2; i <= FACT_NMAX; i++) begin
      if (i <= int'(n)) f = f * FACT_W'(i);
    end
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inverse_factorial_if.sv
`default_nettype none
// ============================================================================
// inverse_factorial_if : start/done handshake and result bus
// Rev 1.0
// ============================================================================
interface inverse_factorial_if #(
  parameter int WIDTH = 32,
  parameter int N_W   = 4
) ();

  logic             start;
  logic [WIDTH-1:0] value;
  logic [N_W-1:0]   n_out;
  logic             exact;
  logic             invalid;
  logic             busy;
  logic             done;

  modport master (
    output start, value,
    input  n_out, exact, invalid, busy, done
  );

  modport slave (
    input  start, value,
    output n_out, exact, invalid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/inv_fact_step.sv
`default_nettype none
// ============================================================================
// inv_fact_step : one candidate of the inverse-factorial search (combinational)
// Rev 1.0
// ============================================================================
module inv_fact_step #(
  parameter int WIDTH = 32,
  parameter int N_W   = 4,
  parameter int N_MAX = 12
) (
  input  logic [WIDTH-1:0]     prod_i,
  input  logic [N_W-1:0]       k_i,
  input  logic [WIDTH-1:0]     v_i,
  output logic [WIDTH+N_W-1:0] nxt_o,
  output logic                 stop_o,
  output logic                 is_exact_o
);

  logic [N_W-1:0] kp1;

  // k never exceeds N_MAX here, so k+1 fits in N_W bits and nxt cannot wrap
  assign kp1        = k_i + N_W'(1);
  assign nxt_o      = {{N_W{1'b0}}, prod_i} * {{WIDTH{1'b0}}, kp1};
  assign stop_o     = (nxt_o > {{N_W{1'b0}}, v_i}) || (k_i == N_W'(N_MAX));
  assign is_exact_o = (prod_i == v_i);

endmodule
`default_nettype wire

// File: rtl/inverse_factorial.sv
`default_nettype none
// ============================================================================
// inverse_factorial : largest n with n! <= V, one candidate per clock
// Rev 1.0
// ============================================================================
module inverse_factorial
  import math_pkg::*;
#(
  parameter int WIDTH = FACT_W,
  parameter int N_MAX = FACT_NMAX,
  parameter int N_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  inverse_factorial_if.slave  io
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   v_q, v_d;
  logic [WIDTH-1:0]   prod_q, prod_d;
  logic [N_W-1:0]     k_q, k_d;
  logic [N_W-1:0]     n_q, n_d;
  logic               exact_q, exact_d;
  logic               invalid_q, invalid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH+N_W-1:0] nxt;
  logic                 stop;
  logic                 is_exact;

  inv_fact_step #(
    .WIDTH (WIDTH),
    .N_W   (N_W),
    .N_MAX (N_MAX)
  ) u_step (
    .prod_i     (prod_q),
    .k_i        (k_q),
    .v_i        (v_q),
    .nxt_o      (nxt),
    .stop_o     (stop),
    .is_exact_o (is_exact)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      v_q       <= '0;
      prod_q    <= WIDTH'(1);
      k_q       <= N_W'(1);
      n_q       <= '0;
      exact_q   <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      prod_q    <= prod_d;
      k_q       <= k_d;
      n_q       <= n_d;
      exact_q   <= exact_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // A start in any state restarts the search; an in-flight one is dropped
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    prod_d    = prod_q;
    k_d       = k_q;
    n_d       = n_q;
    exact_d   = exact_q;
    invalid_d = invalid_q;
    busy_d    = busy_q;
    done_d    = done_q;
    if (io.start) begin
      v_d     = io.value;
      prod_d  = WIDTH'(1);
      k_d     = N_W'(1);
      done_d  = 1'b0;
      busy_d  = 1'b1;
      state_d = CALC;
    end else begin
      case (state_q)
        CALC: begin
          if (v_q == '0) begin
            invalid_d = 1'b1;
            n_d       = '0;
            exact_d   = 1'b0;
            state_d   = FIN;
          end else if (stop) begin
            n_d       = k_q;
            exact_d   = is_exact;
            invalid_d = 1'b0;
            state_d   = FIN;
          end else begin
            prod_d = nxt[WIDTH-1:0];
            k_d    = k_q + N_W'(1);
          end
        end
        FIN: begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign io.n_out   = n_q;
  assign io.exact   = exact_q;
  assign io.invalid = invalid_q;
  assign io.busy    = busy_q;
  assign io.done    = done_q;

`ifndef SYNTHESIS
  a_prod_is_fact: assert property (@(posedge clk) disable iff (reset)
    (state_q == CALC) |-> (prod_q == fact_ref(32'(k_q))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_inverse_factorial.sv
`default_nettype none
// ============================================================================
// tb_inverse_factorial : directed + random checks against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_inverse_factorial;
  import math_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  inverse_factorial_if #(.WIDTH(32), .N_W(4)) bus ();

  inverse_factorial #(.WIDTH(32), .N_MAX(12), .N_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Largest n in 1..12 with n! <= v, by straight arithmetic on 64-bit values
  task automatic model(input logic [31:0] v, output int n, output bit ex,
                       output bit inv, output int lat);
    longint unsigned f;
    f   = 1;
    n   = 0;
    inv = (v == 0);
    if (!inv) begin
      n = 1;
      while (n < 12 && f * longint'(n + 1) <= longint'(v)) begin
        n++;
        f = f * longint'(n);
      end
    end
    ex  = !inv && (f == longint'(v));
    lat = inv ? 3 : n + 2;
  endtask

  function automatic longint unsigned fact64(input int n);
    longint unsigned f = 1;
    for (int i = 2; i <= n; i++) f = f * longint'(i);
    return f;
  endfunction

  task automatic do_start(input logic [31:0] v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = v;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    while (bus.done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic run(input logic [31:0] v);
    int n, lat, edges;
    bit ex, inv;
    model(v, n, ex, inv, lat);
    do_start(v);
    wait_done(edges);
    check($sformatf("n_out v=%0d", v),   64'(bus.n_out),   64'(n));
    check($sformatf("exact v=%0d", v),   64'(bus.exact),   64'(ex));
    check($sformatf("invalid v=%0d", v), 64'(bus.invalid), 64'(inv));
    check($sformatf("busy v=%0d", v),    64'(bus.busy),    64'd0);
    check($sformatf("latency v=%0d", v), 64'(edges),       64'(lat));
  endtask

  initial begin
    logic [31:0] v;
    int edges;
    bus.start = 1'b0;
    bus.value = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst n_out",   64'(bus.n_out),   64'd0);
    check("rst exact",   64'(bus.exact),   64'd0);
    check("rst invalid", 64'(bus.invalid), 64'd0);
    check("rst busy",    64'(bus.busy),    64'd0);
    check("rst done",    64'(bus.done),    64'd0);

    run(32'd120);
    run(32'd121);
    run(32'd719);
    run(32'd720);
    run(32'd1);
    run(32'd2);
    run(32'd0);
    run(32'd479001600);
    run(32'hFFFF_FFFF);

    // Restart while busy: only the second search may complete
    do_start(32'd3628800);
    repeat (2) begin
      @(negedge clk);
      check("restart no early done", 64'(bus.done), 64'd0);
      check("restart busy",          64'(bus.busy), 64'd1);
    end
    do_start(32'd24);
    wait_done(edges);
    check("restart n_out",   64'(bus.n_out), 64'd4);
    check("restart exact",   64'(bus.exact), 64'd1);
    check("restart latency", 64'(edges),     64'd6);

    // Reset mid-search dominates a simultaneous start
    do_start(32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.value = 32'd5;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check("midrst busy",    64'(bus.busy),    64'd0);
    check("midrst done",    64'(bus.done),    64'd0);
    check("midrst n_out",   64'(bus.n_out),   64'd0);
    check("midrst exact",   64'(bus.exact),   64'd0);
    check("midrst invalid", 64'(bus.invalid), 64'd0);
    @(negedge clk);
    check("midrst stays idle", 64'(bus.busy), 64'd0);
    run(32'd6);

    // Round trip through the shared factorial helper
    for (int n = 0; n <= 12; n++) begin
      check($sformatf("fact_ref %0d", n), 64'(fact_ref(n)), fact64(n));
      run(32'(fact64(n)));
    end

    // Random values: full range, exact factorials, neighbours, and small values
    for (int i = 0; i < 40; i++) begin
      int n;
      n = int'($urandom_range(1, 12));
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = 32'(fact64(n));
        2: v = 32'(fact64(n)) + 32'($urandom_range(0, 2)) - 32'd1;
        default: v = 32'($urandom_range(0, 1000));
      endcase
      run(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
